op_prep_stage: RTL and testbench
================================

# op_prep_stage

Parametrised operand-preparation pipeline stage, sitting between decode (ID) and execute (EX). It generalises operand preparation to NOPS source operands and NFWD downstream forwarding sources. Its hazard detection inserts bubbles when a producer's value is not yet available, and it carries a saturating bubble-cycle counter. The stage owns the OP/EX pipeline register and is the only place where read-after-write hazards against in-flight instructions are resolved.

## Interface
Parameters:
- NOPS, 2: source operands per instruction (2..3)
- NFWD, 3: downstream forwarding sources; index 0 is youngest (EX), NFWD-1 is oldest (WB) (1..4)
- PW, 21: payload width

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset, asynchronous, active-low
- s_stall_i  in  1  downstream stall; OP/EX register must hold
- s_flush_i  in  1  flush; OP/EX register loads a NOP
- s_stall_o  out  1  bubble request; ID must hold its instruction
- s_id_valid_i  in  1  ID presents an instruction
- s_id_err_i  in  1  ID-detected error; instruction passes as a non-writing error carrier
- s_id_rs_i  in  NOPS×5  source register addresses
- s_id_use_i  in  NOPS  operand reads the register file
- s_id_rfval_i  in  NOPS×32  register-file read values
- s_id_imm_i  in  32  immediate
- s_id_immsel_i  in  NOPS  operand takes the immediate instead of a register
- s_id_rd_i  in  5  destination register
- s_id_wr_i  in  1  instruction writes rd
- s_id_payload_i  in  PW  opaque payload
- s_fwd_rd_i  in  NFWD×5  destination register of each downstream stage
- s_fwd_wr_i  in  NFWD  downstream stage writes the register file
- s_fwd_rdy_i  in  NFWD  downstream stage's result value is valid
- s_fwd_val_i  in  NFWD×32  downstream stage result
- s_cnt_clr_i  in  1  synchronous clear of the bubble counter
- s_opex_valid_o  out  1  EX holds a real instruction; reset 0
- s_opex_op_o  out  NOPS×32  prepared operands; reset 0
- s_opex_rd_o  out  5  reset 0
- s_opex_wr_o  out  1  reset 0
- s_opex_err_o  out  1  reset 0
- s_opex_payload_o  out  PW  reset 0
- s_bubble_cnt_o  out  16  bubble counter; reset 0

## Operation
Per-operand selection, combinational, operand i:
- If immsel[i] is set: the immediate is selected.
- If use[i] is clear or rs[i] is 0: the rfval is selected, and no hazard is raised.
- Otherwise, find the youngest k with fwd_wr[k] set and fwd_rd[k]==rs[i].
  - Match found and rdy[k] set: fwd_val[k] is selected.
  - Match found and rdy[k] clear: hazard. An older ready match does not override the hazard.
  - No match: rfval is selected.
- hazard = id_valid & OR of the per-operand hazards & ~s_id_err_i.
- s_stall_o = hazard, combinational.

Register update priority:
1. flush
2. s_stall_i
3. hazard
4. load

- Flush: the OP/EX register is loaded with all zeros, valid=0 and wr=0.
- Stall: the OP/EX register holds.
- Hazard: a NOP is inserted, all fields 0.
- Load: the ID fields and prepared operands are registered and valid=id_valid.
  - If err is set, wr=0 and err=1.

Bubble counter:
- Increments by 1 when hazard & ~s_stall_i & ~s_flush_i.
- Saturates at 0xFFFF.
- s_cnt_clr_i has priority over increment.

## Timing
- Operand preparation to output: 1 cycle (register).
- s_stall_o is valid in the same cycle as the ID inputs.
- A hazard persists each cycle until the producer sets rdy or retires; one NOP is inserted per hazard cycle.
- Hazard during s_stall_i: s_stall_o stays 1, the register holds, and the counter does not increment.
- Simultaneous flush and hazard: a NOP is inserted and the counter does not increment.
- Reset asserted mid-operation clears all outputs asynchronously. The first load is on the first clock edge after deassertion.

## Configuration
- OP_FWD_EN defined:
  - Full forwarding as described above.
- OP_FWD_EN undefined:
  - Interlock-only operation: any match (wr & rd==rs) is a hazard regardless of rdy, and the rfval is always selected.
  - s_fwd_val_i and s_fwd_rdy_i are unused.

## Structure
- Shared package:
  - OP_NFWD_MAX=4 and OP_NOPS_MAX=3, checked by elaboration-time assertions against the parameters.
  - Reuse of the existing rf_add type for all 5-bit addresses.
- Sub-module op_fwd_sel: a per-operand match/priority/ready selector that outputs operand and hazard, instantiated NOPS times.

## Test plan
- No hazards: rs1=3, rs2=4, rfval=0x11/0x22 -> next cycle op0=0x11, op1=0x22, valid=1.
- Forwarding: fwd_rd[1]=3, wr, rdy, val=0xAB; fwd_rd[2]=3 val=0xCD -> op0=0xAB (youngest wins).
- Load-use: fwd_rd[0]=3, rdy=0 for 2 cycles -> s_stall_o=1, two NOPs, counter=2, then operand from the source once ready.
- Interaction: hazard with s_stall_i=1 -> register holds, counter unchanged; flush with hazard -> NOP, counter unchanged.
- rs=0 with fwd_rd[0]=0 and wr -> no hazard, rfval used.
- Counter preset to 0xFFFF plus a bubble -> stays at 0xFFFF; s_cnt_clr_i -> 0. Build with OP_FWD_EN undefined: a ready match still stalls.

Source files
------------

// File: rtl/op_prep_stage_pkg.sv
// Shared types, limits and helpers for the operand-preparation stage.
// Optional feature macro: OP_FWD_EN (full forwarding when defined,
// interlock-only operation when undefined).
package op_prep_stage_pkg;

  // Upper bounds on the stage parameters.
  localparam int OP_NFWD_MAX = 4;
  localparam int OP_NOPS_MAX = 3;
  localparam int OP_XLEN     = 32;
  localparam int OP_CNT_W    = 16;

  // Register-file address used for every 5-bit register index.
  typedef logic [4:0] rf_add;

  // Where a prepared operand came from.
  // The encoding is informational only; the datapath never stores it.
  typedef enum logic [1:0] {
    OP_SRC_RF  = 2'd0,
    OP_SRC_IMM = 2'd1,
    OP_SRC_FWD = 2'd2
  } op_src_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [OP_CNT_W-1:0] sat_inc(input logic [OP_CNT_W-1:0] v);
    if (v == {OP_CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(OP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/op_prep_stage_fwd_sel.sv
// Per-operand selector: picks immediate, register-file value or a
// forwarded result, and flags a hazard when the youngest in-flight
// writer of the source register cannot supply its value yet.
// Optional feature macro: OP_FWD_EN.
module op_fwd_sel
  import op_prep_stage_pkg::*;
#(
  parameter int NFWD = 3
) (
  input  rf_add                    i_rs,
  input  logic                     i_use,
  input  logic                     i_immsel,
  input  logic [OP_XLEN-1:0]       i_rfval,
  input  logic [OP_XLEN-1:0]       i_imm,
  input  rf_add [NFWD-1:0]         i_fwd_rd,
  input  logic [NFWD-1:0]          i_fwd_wr,
  input  logic [NFWD-1:0]          i_fwd_rdy,
  input  logic [NFWD*OP_XLEN-1:0]  i_fwd_val,
  output logic [OP_XLEN-1:0]       o_operand,
  output logic                     o_hazard
);

  logic                w_found;
  op_src_e             w_src;
`ifdef OP_FWD_EN
  logic                w_rdy;
  logic [OP_XLEN-1:0]  w_val;
`else
  logic                w_unused_fwd;
`endif

  // Youngest-match search: scan oldest to youngest so the youngest
  // matching writer is the one left standing.
  always_comb begin
    w_found = 1'b0;
`ifdef OP_FWD_EN
    w_rdy   = 1'b0;
    w_val   = '0;
`endif
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_fwd_wr[k] && (i_fwd_rd[k] == i_rs)) begin
        w_found = 1'b1;
`ifdef OP_FWD_EN
        w_rdy   = i_fwd_rdy[k];
        w_val   = i_fwd_val[k*OP_XLEN +: OP_XLEN];
`endif
      end
    end
  end

`ifndef OP_FWD_EN
  // Interlock-only build never looks at forwarded values or readiness.
  assign w_unused_fwd = ^{i_fwd_rdy, i_fwd_val};
`endif

  // Source selection and hazard decision for this operand.
  always_comb begin
    w_src    = OP_SRC_RF;
    o_hazard = 1'b0;
    if (i_immsel) begin
      w_src = OP_SRC_IMM;
    end else if (!i_use || (i_rs == 5'd0)) begin
      w_src = OP_SRC_RF;
    end else if (w_found) begin
`ifdef OP_FWD_EN
      if (w_rdy) begin
        w_src = OP_SRC_FWD;
      end else begin
        o_hazard = 1'b1;
      end
`else
      o_hazard = 1'b1;
`endif
    end
  end

  // Operand mux driven by the selected source.
  always_comb begin
    o_operand = i_rfval;
    case (w_src)
      OP_SRC_IMM: o_operand = i_imm;
`ifdef OP_FWD_EN
      OP_SRC_FWD: o_operand = w_val;
`endif
      default:    o_operand = i_rfval;
    endcase
  end

endmodule

// File: rtl/op_prep_stage.sv
// Operand-preparation stage between ID and EX. Resolves read-after-write
// hazards against in-flight instructions, owns the OP/EX register and
// counts bubble cycles in a saturating counter.
// Optional feature macro: OP_FWD_EN (forwarding; otherwise interlock only).
module op_prep_stage
  import op_prep_stage_pkg::*;
#(
  parameter int NOPS = 2,
  parameter int NFWD = 3,
  parameter int PW   = 21
) (
  input  logic                     s_clk_i,
  input  logic                     s_resetn_i,
  input  logic                     s_stall_i,
  input  logic                     s_flush_i,
  output logic                     s_stall_o,
  input  logic                     s_id_valid_i,
  input  logic                     s_id_err_i,
  input  logic [NOPS*5-1:0]        s_id_rs_i,
  input  logic [NOPS-1:0]          s_id_use_i,
  input  logic [NOPS*OP_XLEN-1:0]  s_id_rfval_i,
  input  logic [OP_XLEN-1:0]       s_id_imm_i,
  input  logic [NOPS-1:0]          s_id_immsel_i,
  input  logic [4:0]               s_id_rd_i,
  input  logic                     s_id_wr_i,
  input  logic [PW-1:0]            s_id_payload_i,
  input  logic [NFWD*5-1:0]        s_fwd_rd_i,
  input  logic [NFWD-1:0]          s_fwd_wr_i,
  input  logic [NFWD-1:0]          s_fwd_rdy_i,
  input  logic [NFWD*OP_XLEN-1:0]  s_fwd_val_i,
  input  logic                     s_cnt_clr_i,
  output logic                     s_opex_valid_o,
  output logic [NOPS*OP_XLEN-1:0]  s_opex_op_o,
  output logic [4:0]               s_opex_rd_o,
  output logic                     s_opex_wr_o,
  output logic                     s_opex_err_o,
  output logic [PW-1:0]            s_opex_payload_o,
  output logic [OP_CNT_W-1:0]      s_bubble_cnt_o
);

  // Parameter range checks at elaboration.
  if ((NOPS < 2) || (NOPS > OP_NOPS_MAX)) begin : g_bad_nops
    $fatal(1, "op_prep_stage: NOPS out of range");
  end
  if ((NFWD < 1) || (NFWD > OP_NFWD_MAX)) begin : g_bad_nfwd
    $fatal(1, "op_prep_stage: NFWD out of range");
  end

  logic [NOPS*OP_XLEN-1:0] w_op;
  logic [NOPS-1:0]         w_op_haz;
  logic                    w_hazard;
  logic                    w_bubble;

  logic                    r_valid;
  logic [NOPS*OP_XLEN-1:0] r_op;
  rf_add                   r_rd;
  logic                    r_wr;
  logic                    r_err;
  logic [PW-1:0]           r_payload;
  logic [OP_CNT_W-1:0]     r_cnt;

  // One selector per source operand.
  for (genvar gi = 0; gi < NOPS; gi++) begin : g_op
    op_fwd_sel #(
      .NFWD (NFWD)
    ) u_sel (
      .i_rs      (s_id_rs_i[gi*5 +: 5]),
      .i_use     (s_id_use_i[gi]),
      .i_immsel  (s_id_immsel_i[gi]),
      .i_rfval   (s_id_rfval_i[gi*OP_XLEN +: OP_XLEN]),
      .i_imm     (s_id_imm_i),
      .i_fwd_rd  (s_fwd_rd_i),
      .i_fwd_wr  (s_fwd_wr_i),
      .i_fwd_rdy (s_fwd_rdy_i),
      .i_fwd_val (s_fwd_val_i),
      .o_operand (w_op[gi*OP_XLEN +: OP_XLEN]),
      .o_hazard  (w_op_haz[gi])
    );
  end

  // An errored instruction never writes, so it cannot be held up by a hazard.
  assign w_hazard  = s_id_valid_i & (|w_op_haz) & ~s_id_err_i;
  assign s_stall_o = w_hazard;

  // A bubble is counted only when a NOP actually enters EX.
  assign w_bubble  = w_hazard & ~s_stall_i & ~s_flush_i;

  // OP/EX register: flush beats downstream stall, which beats hazard NOPs.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_payload <= '0;
    end else if (s_flush_i || (!s_stall_i && w_hazard)) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_payload <= '0;
    end else if (!s_stall_i) begin
      r_valid   <= s_id_valid_i;
      r_op      <= w_op;
      r_rd      <= s_id_rd_i;
      r_wr      <= s_id_wr_i & ~s_id_err_i;
      r_err     <= s_id_err_i;
      r_payload <= s_id_payload_i;
    end
  end

  // Saturating bubble counter; a clear wins over a same-cycle bubble.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_cnt <= '0;
    end else if (s_cnt_clr_i) begin
      r_cnt <= '0;
    end else if (w_bubble) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign s_opex_valid_o   = r_valid;
  assign s_opex_op_o      = r_op;
  assign s_opex_rd_o      = r_rd;
  assign s_opex_wr_o      = r_wr;
  assign s_opex_err_o     = r_err;
  assign s_opex_payload_o = r_payload;
  assign s_bubble_cnt_o   = r_cnt;

endmodule

// File: tb/tb_op_prep_stage.sv
// Directed bench for op_prep_stage (NOPS=2, NFWD=3, PW=21).
// Expectations follow the OP_FWD_EN setting the bench is compiled with.
module tb_op_prep_stage;

  localparam int NOPS = 2;
  localparam int NFWD = 3;
  localparam int PW   = 21;

  logic                clk;
  logic                rstN;
  logic                stallIn;
  logic                flush;
  logic                stallOut;
  logic                idValid;
  logic                idErr;
  logic [NOPS*5-1:0]   idRs;
  logic [NOPS-1:0]     idUse;
  logic [NOPS*32-1:0]  idRfval;
  logic [31:0]         idImm;
  logic [NOPS-1:0]     idImmsel;
  logic [4:0]          idRd;
  logic                idWr;
  logic [PW-1:0]       idPayload;
  logic [NFWD*5-1:0]   fwdRd;
  logic [NFWD-1:0]     fwdWr;
  logic [NFWD-1:0]     fwdRdy;
  logic [NFWD*32-1:0]  fwdVal;
  logic                cntClr;
  logic                opexValid;
  logic [NOPS*32-1:0]  opexOp;
  logic [4:0]          opexRd;
  logic                opexWr;
  logic                opexErr;
  logic [PW-1:0]       opexPayload;
  logic [15:0]         bubbleCnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] expCnt;

  op_prep_stage #(
    .NOPS (NOPS),
    .NFWD (NFWD),
    .PW   (PW)
  ) dut (
    .s_clk_i          (clk),
    .s_resetn_i       (rstN),
    .s_stall_i        (stallIn),
    .s_flush_i        (flush),
    .s_stall_o        (stallOut),
    .s_id_valid_i     (idValid),
    .s_id_err_i       (idErr),
    .s_id_rs_i        (idRs),
    .s_id_use_i       (idUse),
    .s_id_rfval_i     (idRfval),
    .s_id_imm_i       (idImm),
    .s_id_immsel_i    (idImmsel),
    .s_id_rd_i        (idRd),
    .s_id_wr_i        (idWr),
    .s_id_payload_i   (idPayload),
    .s_fwd_rd_i       (fwdRd),
    .s_fwd_wr_i       (fwdWr),
    .s_fwd_rdy_i      (fwdRdy),
    .s_fwd_val_i      (fwdVal),
    .s_cnt_clr_i      (cntClr),
    .s_opex_valid_o   (opexValid),
    .s_opex_op_o      (opexOp),
    .s_opex_rd_o      (opexRd),
    .s_opex_wr_o      (opexWr),
    .s_opex_err_o     (opexErr),
    .s_opex_payload_o (opexPayload),
    .s_bubble_cnt_o   (bubbleCnt)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one ID instruction with both operands reading registers.
  task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [31:0] rf0, input logic [31:0] rf1);
    idValid   = 1'b1;
    idErr     = 1'b0;
    idRs      = {rs1, rs0};
    idUse     = 2'b11;
    idRfval   = {rf1, rf0};
    idImm     = 32'h0000_0F0F;
    idImmsel  = 2'b00;
    idRd      = 5'd9;
    idWr      = 1'b1;
    idPayload = 21'h1ABCD;
  endtask

  task automatic setFwd(input int k, input logic [4:0] rd, input logic wr,
                        input logic rdy, input logic [31:0] val);
    fwdRd[k*5 +: 5]   = rd;
    fwdWr[k]          = wr;
    fwdRdy[k]         = rdy;
    fwdVal[k*32 +: 32] = val;
  endtask

  task automatic clearFwd();
    fwdRd  = '0;
    fwdWr  = '0;
    fwdRdy = '0;
    fwdVal = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN     = 1'b0;
    stallIn  = 1'b0;
    flush    = 1'b0;
    cntClr   = 1'b0;
    applyStimulus(5'd0, 5'd0, 32'h0, 32'h0);
    idValid  = 1'b0;
    clearFwd();
    expCnt   = 16'd0;

    // Reset state.
    #12;
    checkOutput("reset_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("reset_op0", opexOp[31:0], 32'd0);
    checkOutput("reset_cnt", {16'd0, bubbleCnt}, 32'd0);
    rstN = 1'b1;

    // No hazard: register-file values pass through.
    applyStimulus(5'd3, 5'd4, 32'h11, 32'h22);
    #1;
    checkOutput("nohaz_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("nohaz_op0", opexOp[31:0], 32'h11);
    checkOutput("nohaz_op1", opexOp[63:32], 32'h22);
    checkOutput("nohaz_valid", {31'd0, opexValid}, 32'd1);
    checkOutput("nohaz_rd", {27'd0, opexRd}, 32'd9);
    checkOutput("nohaz_wr", {31'd0, opexWr}, 32'd1);
    checkOutput("nohaz_payload", {11'd0, opexPayload}, 32'h1ABCD);

    // Two ready writers of r3: the younger (index 1) must win.
    setFwd(1, 5'd3, 1'b1, 1'b1, 32'hAB);
    setFwd(2, 5'd3, 1'b1, 1'b1, 32'hCD);
    #1;
`ifdef OP_FWD_EN
    checkOutput("fwd_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("fwd_op0_youngest", opexOp[31:0], 32'hAB);
    checkOutput("fwd_op1_rf", opexOp[63:32], 32'h22);
`else
    checkOutput("ilk_ready_match_stall", {31'd0, stallOut}, 32'd1);
    tick();
    expCnt = expCnt + 16'd1;
    checkOutput("ilk_nop_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("ilk_cnt", {16'd0, bubbleCnt}, {16'd0, expCnt});
`endif

    // Load-use: youngest writer not ready; an older ready match must not help.
    clearFwd();
    setFwd(0, 5'd3, 1'b1, 1'b0, 32'h77);
    setFwd(1, 5'd3, 1'b1, 1'b1, 32'hAB);
    #1;
    checkOutput("lu_stall", {31'd0, stallOut}, 32'd1);
    tick();
    expCnt = expCnt + 16'd1;
    checkOutput("lu_nop1_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("lu_nop1_op0", opexOp[31:0], 32'd0);
    tick();
    expCnt = expCnt + 16'd1;
    checkOutput("lu_nop2_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("lu_cnt", {16'd0, bubbleCnt}, {16'd0, expCnt});
    setFwd(0, 5'd3, 1'b1, 1'b1, 32'h77);
    #1;
`ifdef OP_FWD_EN
    checkOutput("lu_ready_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("lu_ready_op0", opexOp[31:0], 32'h77);
    checkOutput("lu_ready_valid", {31'd0, opexValid}, 32'd1);
`else
    checkOutput("lu_ready_ilk_stall", {31'd0, stallOut}, 32'd1);
    tick();
    expCnt = expCnt + 16'd1;
    clearFwd();
    #1;
    checkOutput("lu_retire_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("lu_retire_op0", opexOp[31:0], 32'h11);
`endif

    // Load a known value, then a hazard under downstream stall: hold.
    clearFwd();
    applyStimulus(5'd5, 5'd6, 32'h55, 32'h66);
    tick();
    checkOutput("pre_hold_op0", opexOp[31:0], 32'h55);
    setFwd(0, 5'd6, 1'b1, 1'b0, 32'h0);
    stallIn = 1'b1;
    #1;
    checkOutput("hold_stall_o", {31'd0, stallOut}, 32'd1);
    tick();
    checkOutput("hold_op0", opexOp[31:0], 32'h55);
    checkOutput("hold_op1", opexOp[63:32], 32'h66);
    checkOutput("hold_valid", {31'd0, opexValid}, 32'd1);
    checkOutput("hold_cnt", {16'd0, bubbleCnt}, {16'd0, expCnt});

    // Flush with hazard: NOP, counter unchanged.
    stallIn = 1'b0;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    checkOutput("flush_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("flush_op0", opexOp[31:0], 32'd0);
    checkOutput("flush_cnt", {16'd0, bubbleCnt}, {16'd0, expCnt});

    // rs=0 matching a writer of r0: no hazard, register-file value.
    clearFwd();
    setFwd(0, 5'd0, 1'b1, 1'b0, 32'h0);
    applyStimulus(5'd0, 5'd4, 32'h99, 32'h22);
    #1;
    checkOutput("r0_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("r0_op0", opexOp[31:0], 32'h99);

    // Immediate on an operand whose register is busy: no hazard.
    clearFwd();
    setFwd(0, 5'd3, 1'b1, 1'b0, 32'h0);
    applyStimulus(5'd3, 5'd4, 32'h11, 32'h22);
    idImmsel = 2'b01;
    #1;
    checkOutput("imm_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("imm_op0", opexOp[31:0], 32'h0F0F);

    // Error carrier with a hazard: passes through, never writes.
    idImmsel = 2'b00;
    idErr    = 1'b1;
    #1;
    checkOutput("err_stall", {31'd0, stallOut}, 32'd0);
    tick();
    checkOutput("err_err", {31'd0, opexErr}, 32'd1);
    checkOutput("err_wr", {31'd0, opexWr}, 32'd0);
    checkOutput("err_valid", {31'd0, opexValid}, 32'd1);
    idErr = 1'b0;

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_valid", {31'd0, opexValid}, 32'd0);
    checkOutput("async_op1", opexOp[63:32], 32'd0);
    checkOutput("async_cnt", {16'd0, bubbleCnt}, 32'd0);
    #2;
    rstN = 1'b1;
    expCnt = 16'd0;

    // Saturation: r3 still busy at index 0, run 65535 bubbles and one more.
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    checkOutput("sat_full", {16'd0, bubbleCnt}, 32'h0000FFFF);
    tick();
    checkOutput("sat_hold", {16'd0, bubbleCnt}, 32'h0000FFFF);
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    checkOutput("clr_cnt", {16'd0, bubbleCnt}, 32'd0);
    tick();
    checkOutput("post_clr_cnt", {16'd0, bubbleCnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
